// File: rtl/fifo_traffic_gen_pkg.sv
// fifo_traffic_gen_pkg: shared types and constants for the FIFO traffic generator.
package fifo_traffic_gen_pkg;
    typedef enum logic [2:0] {IDLE, FILL, DRAIN, RAND, DONE} gen_state_e;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int CNT_W = 32;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0.
module lfsr16 import fifo_traffic_gen_pkg::*; #(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] q
);
    // an all-zero seed would lock the register, so it is replaced by 1
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    always_ff @(posedge clk) begin
        if (load)
            q <= INIT;
        else if (advance)
            q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
endmodule

// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: fill/drain/random FIFO stimulus source with accepted-write/read counters.
// Define FIFO_TRAFFIC_GEN_OVF_EN to ungate RAND traffic and add saturating ovf/udf counters.
module fifo_traffic_gen import fifo_traffic_gen_pkg::*; #(
    parameter int          FIFO_WIDTH = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int          NUM_TXN    = 1000,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  wr_ack,
    input  logic                  overflow,
    input  logic                  underflow,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      wr_count,
    output logic [CNT_W-1:0]      rd_count
`ifdef FIFO_TRAFFIC_GEN_OVF_EN
    ,
    output logic [15:0]           ovf_count,
    output logic [15:0]           udf_count
`endif
);
    localparam int DCW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = (FIFO_WIDTH < 16) ? FIFO_WIDTH : 16;
`ifdef FIFO_TRAFFIC_GEN_OVF_EN
    localparam bit RAND_GATED = 1'b0;
`else
    localparam bit RAND_GATED = 1'b1;
`endif

    gen_state_e       state, nxt;
    logic [15:0]      lfsr;
    logic [DCW-1:0]   data_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic             restart;
    logic             last_txn;

    assign restart  = start && (state == IDLE || state == DONE);
    assign last_txn = cyc_cnt == CNT_W'(NUM_TXN - 1);

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .load    (rst),
        .advance (state == RAND),
        .q       (lfsr)
    );

    always_comb begin
        nxt     = state;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        case (state)
            IDLE:  nxt = start ? FILL : IDLE;
            FILL: begin
                wr_en   = !full;
                data_in = FIFO_WIDTH'(data_cnt);
                nxt     = full ? DRAIN : FILL;
            end
            DRAIN: begin
                rd_en = !empty;
                nxt   = empty ? RAND : DRAIN;
            end
            RAND: begin
                wr_en   = lfsr[0] & !(RAND_GATED & full);
                rd_en   = lfsr[1] & !(RAND_GATED & empty);
                data_in = FIFO_WIDTH'(lfsr[LW-1:0]);
                nxt     = last_txn ? DONE : RAND;
            end
            DONE:    nxt = start ? FILL : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_cnt <= '0;
            cyc_cnt  <= '0;
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            state    <= nxt;
            busy     <= nxt inside {FILL, DRAIN, RAND};
            done     <= nxt == DONE;
            data_cnt <= restart ? '0 : data_cnt + DCW'(wr_en);
            cyc_cnt  <= restart ? '0 : cyc_cnt + CNT_W'(state == RAND);
            wr_count <= restart ? '0 : wr_count + CNT_W'(wr_ack && state != IDLE);
            rd_count <= restart ? '0 : rd_count + CNT_W'(rd_en && !empty);
        end
    end

`ifdef FIFO_TRAFFIC_GEN_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
            udf_count <= '0;
        end else begin
            ovf_count <= restart ? '0 : ovf_count + 16'(overflow && ovf_count != 16'hFFFF);
            udf_count <= restart ? '0 : udf_count + 16'(underflow && udf_count != 16'hFFFF);
        end
    end
`else
    // flow-control errors cannot occur while all traffic is gated
    logic unused_flags;
    assign unused_flags = overflow ^ underflow;
`endif
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen: vector table on a SEED=0 instance, then a full run against a queue FIFO and phase model.
`timescale 1ns/1ps
module tb_fifo_traffic_gen;
    localparam int W = 16;
    localparam int DEPTH = 8;
    localparam int NTXN = 1000;
    localparam int NTXN0 = 4;
    localparam logic [15:0] SEED_MAIN = 16'hACE1;
`ifdef FIFO_TRAFFIC_GEN_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, full = 1'b0, empty = 1'b1, wr_ack = 1'b0, overflow = 1'b0, underflow = 1'b0;
    logic wr_en, rd_en, busy, done;
    logic [W-1:0] data_in;
    logic [31:0] wr_count, rd_count;

    logic s0_rst = 1'b1, s0_start = 1'b0, s0_full = 1'b0, s0_empty = 1'b1;
    logic s0_wr, s0_rd, s0_busy, s0_done;
    logic [15:0] s0_d;
    logic [31:0] s0_wcnt, s0_rcnt;
`ifdef FIFO_TRAFFIC_GEN_OVF_EN
    logic [15:0] ovf_count, udf_count, s0_ovf, s0_udf;
`endif

    fifo_traffic_gen #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .NUM_TXN(NTXN), .SEED(SEED_MAIN)) u_dut (
        .clk(clk), .rst(rst), .start(start), .full(full), .empty(empty), .wr_ack(wr_ack),
        .overflow(overflow), .underflow(underflow), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .busy(busy), .done(done), .wr_count(wr_count), .rd_count(rd_count)
`ifdef FIFO_TRAFFIC_GEN_OVF_EN
        , .ovf_count(ovf_count), .udf_count(udf_count)
`endif
    );

    fifo_traffic_gen #(.FIFO_WIDTH(16), .FIFO_DEPTH(DEPTH), .NUM_TXN(NTXN0), .SEED(16'h0000)) u_seed0 (
        .clk(clk), .rst(s0_rst), .start(s0_start), .full(s0_full), .empty(s0_empty), .wr_ack(1'b0),
        .overflow(1'b0), .underflow(1'b0), .wr_en(s0_wr), .rd_en(s0_rd), .data_in(s0_d),
        .busy(s0_busy), .done(s0_done), .wr_count(s0_wcnt), .rd_count(s0_rcnt)
`ifdef FIFO_TRAFFIC_GEN_OVF_EN
        , .ovf_count(s0_ovf), .udf_count(s0_udf)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    typedef struct packed {
        logic start, full, empty, wr, rd;
        logic [15:0] d;
        logic busy, done;
    } vec_t;
    vec_t tv[13];

    function automatic vec_t rand_row(input logic f, input logic e, input logic [15:0] l);
        return {1'b0, f, e, l[0] & (OVF | !f), l[1] & (OVF | !e), l, 1'b1, 1'b0};
    endfunction

    typedef enum {P_IDLE, P_FILL, P_DRAIN, P_RAND, P_DONE} phase_t;
    phase_t ph = P_IDLE;
    logic [15:0] m_lfsr = SEED_MAIN;
    int m_cyc = 0, m_data = 0;
    logic [31:0] m_wr = '0, m_rd = '0;
    logic [W-1:0] q[$];
    logic [W-1:0] drained[$];
    int sb_push = 0, sb_pop = 0, ovf_seen = 0, udf_seen = 0;
    logic force_full = 1'b0;
    int forced_wr = 0, forced_exp = 0;

    // One clock of the main run: check at negedge, then apply FIFO and model updates after the edge.
    task automatic tick();
        logic ew, er, a_wr, a_rd, s_rst, s_start, s_full, s_empty, s_ack, ack_n, ovf_n, udf_n;
        logic [W-1:0] ed, a_d;
        @(negedge clk);
        s_rst = rst; s_start = start; s_full = full; s_empty = empty; s_ack = wr_ack;
        a_wr = wr_en; a_rd = rd_en; a_d = data_in;
        ew = 1'b0; er = 1'b0; ed = '0;
        if (ph == P_FILL) begin
            ew = !s_full;
            ed = W'(m_data);
        end else if (ph == P_DRAIN) begin
            er = !s_empty;
        end else if (ph == P_RAND) begin
            ew = m_lfsr[0] & (OVF | !s_full);
            er = m_lfsr[1] & (OVF | !s_empty);
            ed = m_lfsr;
        end
        check("outputs", {a_wr, a_rd, a_d, busy, done},
              {ew, er, ed, ph inside {P_FILL, P_DRAIN, P_RAND}, ph == P_DONE});
        check("counts", {wr_count, rd_count}, {m_wr, m_rd});
        if (force_full && a_wr) forced_wr++;
        if (force_full && ph == P_RAND && OVF && m_lfsr[0]) forced_exp++;
        @(posedge clk);
        #1;
        ack_n = 1'b0; ovf_n = 1'b0; udf_n = 1'b0;
        if (s_rst) begin
            ph = P_IDLE; m_lfsr = SEED_MAIN; m_data = 0; m_cyc = 0; m_wr = '0; m_rd = '0;
            q.delete();
        end else begin
            ack_n = a_wr && !s_full;
            ovf_n = a_wr && s_full;
            udf_n = a_rd && s_empty;
            if (a_rd && q.size() > 0) begin
                drained.push_back(q.pop_front());
                sb_pop++;
            end
            if (ack_n) begin
                q.push_back(a_d);
                sb_push++;
            end
            ovf_seen += int'(ovf_n);
            udf_seen += int'(udf_n);
            if (s_ack && ph != P_IDLE) m_wr++;
            if (er && !s_empty) m_rd++;
            if (ew) m_data++;
            if (ph == P_RAND) begin
                m_lfsr = lfsr_step(m_lfsr);
                m_cyc++;
            end
            if ((ph == P_IDLE || ph == P_DONE) && s_start) begin
                ph = P_FILL; m_wr = '0; m_rd = '0; m_data = 0; m_cyc = 0;
                drained.delete(); sb_push = 0; sb_pop = 0; ovf_seen = 0; udf_seen = 0;
            end else if (ph == P_FILL && s_full) ph = P_DRAIN;
            else if (ph == P_DRAIN && s_empty) ph = P_RAND;
            else if (ph == P_RAND && m_cyc == NTXN) ph = P_DONE;
        end
        full = force_full || q.size() == DEPTH;
        empty = q.size() == 0;
        wr_ack = ack_n;
        overflow = ovf_n;
        underflow = udf_n;
    endtask

    initial begin
        int n, k, fs, fl;
        logic [15:0] l;
        // SEED=0 instance: fill 2, full, drain 1, empty, 4 random cycles, done, restart
        l = 16'h0001;
        tv[0]  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tv[1]  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[2]  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        tv[3]  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
        tv[4]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tv[5]  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[6]  = rand_row(1'b1, 1'b0, l); l = lfsr_step(l);
        tv[7]  = rand_row(1'b0, 1'b1, l); l = lfsr_step(l);
        tv[8]  = rand_row(1'b0, 1'b0, l); l = lfsr_step(l);
        tv[9]  = rand_row(1'b0, 1'b0, l);
        tv[10] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tv[11] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tv[12] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        repeat (2) @(posedge clk);
        #1 s0_rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            s0_start = tv[i].start; s0_full = tv[i].full; s0_empty = tv[i].empty;
            @(negedge clk);
            check($sformatf("vec%0d", i), {s0_wr, s0_rd, s0_d, s0_busy, s0_done},
                  {tv[i].wr, tv[i].rd, tv[i].d, tv[i].busy, tv[i].done});
            @(posedge clk);
            #1;
        end
        s0_start = 1'b0;

        tick(); tick();
        rst = 1'b0;
        check("reset", {busy, done, wr_en, rd_en, data_in, wr_count, rd_count}, '0);
        repeat ($urandom_range(1, 4)) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        check("fill3_writes", q.size(), 3);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_fill", {wr_en, busy, done, wr_count}, '0);
        repeat ($urandom_range(0, 3)) tick();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (ph != P_RAND && n < 100) begin
            tick();
            n++;
        end
        check("reach_rand", n < 100, 1);
        check("rand_entry_counts", {wr_count, rd_count}, {32'd8, 32'd8});
        for (int i = 0; i < 8; i++) check($sformatf("drain_order%0d", i), drained[i], 64'(i));

        fs = $urandom_range(50, 300);
        fl = $urandom_range(10, 40);
        k = 0;
        while (!done && k < NTXN + 20) begin
            force_full = k >= fs && k < fs + fl;
            full = force_full || q.size() == DEPTH;
            tick();
            k++;
        end
        force_full = 1'b0;
        full = q.size() == DEPTH;
        check("done_latency", k, NTXN);
        check("hold_full_wr", forced_wr, forced_exp);
        repeat (3) tick();
        check("wr_total", wr_count, sb_push);
        check("rd_total", rd_count, sb_pop);
`ifdef FIFO_TRAFFIC_GEN_OVF_EN
        check("ovf_count", ovf_count, ovf_seen);
        check("udf_count", udf_count, udf_seen);
`else
        check("no_overflow", ovf_seen, 0);
        check("no_underflow", udf_seen, 0);
`endif
        check("done_hold", {busy, done}, 2'b01);
        start = 1'b1; tick(); start = 1'b0;
        check("restart", {busy, done, wr_count == 0, rd_count == 0}, 4'b1011);
        repeat (12) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
